ts_event_capture: RTL and testbench

- Downstream consumer of a tristate line driver.
- Takes the per-line enable/data pairs that feed the tristate buffers and resolves each line to Z, 0 or 1.
- Detects line transitions and queues timestamped event records in a FIFO, read out over a valid/ready interface.
- Sits beside the bus model; the bench or a trace unit drains events in place of $display-style monitoring.

---
 rtl/ts_event_capture.sv | 147 ++++++++++++++
 tb/tb_ts_event_capture.sv | 230 +++++++++++++++++++++++
 2 files changed

// File: rtl/ts_event_capture.sv
// Resolves per-line tristate enable/data to Z/0/1 and queues timestamped transition events.
// Latency: a change seen in cycle c is presented at the FIFO head (ev_valid) in cycle c+2.
// Backpressure: full FIFO holds events in per-line pending slots; only a repeat change on a pending line loses an event (sticky overflow).
// Optional macro TS_EVENT_KEEPER_EN: released lines keep their last driven value instead of going to Z.
module ts_event_capture #(
  parameter int WIDTH = 4,
  parameter int DEPTH = 8,
  parameter int TS_W  = 8
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic [WIDTH-1:0]           drive,
  input  logic [WIDTH-1:0]           d,
  output logic                       ev_valid,
  input  logic                       ev_ready,
  output logic [$clog2(WIDTH)-1:0]   ev_line,
  output logic [1:0]                 ev_state,
  output logic [TS_W-1:0]            ev_time,
  output logic [2*WIDTH-1:0]         level,
  output logic [$clog2(DEPTH):0]     count,
  output logic                       overflow
);

  localparam int LW = $clog2(WIDTH);
  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;
  localparam int EW = LW + 2 + TS_W;

  logic [TS_W-1:0]    ts_q, ts_d;
  logic [2*WIDTH-1:0] level_q, level_d, res;
  logic [WIDTH-1:0]   pend_q, pend_d;
  logic [1:0]         pstate_q [WIDTH];
  logic [1:0]         pstate_d [WIDTH];
  logic [TS_W-1:0]    ptime_q [WIDTH];
  logic [TS_W-1:0]    ptime_d [WIDTH];
  logic               ovf_q, ovf_d;
  logic [EW-1:0]      mem_q [DEPTH];
  logic [EW-1:0]      mem_d [DEPTH];
  logic [AW-1:0]      rd_q, rd_d, wr_q, wr_d;
  logic [CW-1:0]      cnt_q, cnt_d;

  logic               pop, wr_ok, sel_vld, do_wr;
  logic [LW-1:0]      sel;

  // Resolve each line from its buffer enable and data
  always_comb begin
    res = '0;
    for (int i = 0; i < WIDTH; i++) begin
`ifdef TS_EVENT_KEEPER_EN
      res[2*i +: 2] = drive[i] ? {1'b0, d[i]} : level_q[2*i +: 2];
`else
      res[2*i +: 2] = drive[i] ? {1'b0, d[i]} : 2'b10;
`endif
    end
  end

  // Lowest-index pending line wins the single FIFO write slot
  always_comb begin
    pop     = (cnt_q != '0) && ev_ready;
    wr_ok   = (cnt_q != CW'(DEPTH)) || pop;
    sel_vld = 1'b0;
    sel     = '0;
    for (int i = WIDTH - 1; i >= 0; i--) begin
      if (pend_q[i]) begin
        sel_vld = 1'b1;
        sel     = LW'(i);
      end
    end
    do_wr = sel_vld && wr_ok;
  end

  // Pending slot update: grant clears, a new change sets (and coalesces if still pending)
  always_comb begin
    pend_d   = pend_q;
    pstate_d = pstate_q;
    ptime_d  = ptime_q;
    ovf_d    = ovf_q;
    level_d  = res;
    ts_d     = ts_q + TS_W'(1);
    for (int i = 0; i < WIDTH; i++) begin
      if (do_wr && (sel == LW'(i))) begin
        pend_d[i] = 1'b0;
      end
      if (res[2*i +: 2] != level_q[2*i +: 2]) begin
        if (pend_q[i] && !(do_wr && (sel == LW'(i)))) begin
          ovf_d = 1'b1;
        end
        pend_d[i]   = 1'b1;
        pstate_d[i] = res[2*i +: 2];
        ptime_d[i]  = ts_q;
      end
    end
  end

  // Event FIFO pointers, occupancy and storage
  always_comb begin
    mem_d = mem_q;
    wr_d  = wr_q;
    rd_d  = rd_q;
    if (do_wr) begin
      mem_d[wr_q] = {sel, pstate_q[sel], ptime_q[sel]};
      wr_d        = wr_q + AW'(1);
    end
    if (pop) begin
      rd_d = rd_q + AW'(1);
    end
    cnt_d = cnt_q + CW'(do_wr) - CW'(pop);
  end

  // State registers; reset returns every line to Z and drops all events
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ts_q    <= '0;
      level_q <= {WIDTH{2'b10}};
      pend_q  <= '0;
      ovf_q   <= 1'b0;
      rd_q    <= '0;
      wr_q    <= '0;
      cnt_q   <= '0;
      for (int i = 0; i < WIDTH; i++) begin
        pstate_q[i] <= '0;
        ptime_q[i]  <= '0;
      end
      for (int j = 0; j < DEPTH; j++) begin
        mem_q[j] <= '0;
      end
    end else begin
      ts_q     <= ts_d;
      level_q  <= level_d;
      pend_q   <= pend_d;
      pstate_q <= pstate_d;
      ptime_q  <= ptime_d;
      ovf_q    <= ovf_d;
      rd_q     <= rd_d;
      wr_q     <= wr_d;
      cnt_q    <= cnt_d;
      mem_q    <= mem_d;
    end
  end

  assign ev_valid                     = (cnt_q != '0);
  assign {ev_line, ev_state, ev_time} = mem_q[rd_q];
  assign level                        = level_q;
  assign count                        = cnt_q;
  assign overflow                     = ovf_q;

endmodule

// File: tb/tb_ts_event_capture.sv
// Randomized and directed stimulus against a behavioural event model; a monitor
// process compares every consumed event against the expected-event queue.
module tb_ts_event_capture;

  localparam int WIDTH = 4;
  localparam int DEPTH = 8;
  localparam int TS_W  = 8;

  logic             clk = 1'b0;
  logic             rst_n;
  logic [WIDTH-1:0] drive, d;
  logic             ev_valid, ev_ready;
  logic [1:0]       ev_line;
  logic [1:0]       ev_state;
  logic [TS_W-1:0]  ev_time;
  logic [7:0]       level;
  logic [3:0]       count;
  logic             overflow;

  always #5 clk = ~clk;

  ts_event_capture #(.WIDTH(WIDTH), .DEPTH(DEPTH), .TS_W(TS_W)) dut (
    .clk(clk), .rst_n(rst_n), .drive(drive), .d(d),
    .ev_valid(ev_valid), .ev_ready(ev_ready), .ev_line(ev_line),
    .ev_state(ev_state), .ev_time(ev_time), .level(level),
    .count(count), .overflow(overflow)
  );

  typedef struct {
    int line;
    int st;
    int tm;
  } ev_t;

  ev_t exp_q[$];
  int  n_chk  = 0;
  int  n_pass = 0;
  int  last_tm = -1;

  // Behavioural model: line states, one pending record per line, FIFO fill level
  int  m_lvl [WIDTH];
  bit  m_pend[WIDTH];
  int  m_pst [WIDTH];
  int  m_ptm [WIDTH];
  int  m_cnt;
  bit  m_ovf;
  int  m_t;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h (t=%0t)", nm, act, exp, $time);
  endtask

  function automatic void m_reset();
    for (int i = 0; i < WIDTH; i++) begin
      m_lvl[i]  = 2;
      m_pend[i] = 0;
      m_pst[i]  = 0;
      m_ptm[i]  = 0;
    end
    m_cnt = 0;
    m_ovf = 0;
    m_t   = 0;
    exp_q.delete();
  endfunction

  function automatic logic [7:0] m_level();
    logic [7:0] v;
    v = '0;
    for (int i = 0; i < WIDTH; i++) v[2*i +: 2] = 2'(m_lvl[i]);
    return v;
  endfunction

  function automatic bit m_any_pend();
    bit a;
    a = 0;
    for (int i = 0; i < WIDTH; i++) a |= m_pend[i];
    return a;
  endfunction

  // Advance the model across one rising edge with the given inputs
  function automatic void m_step(input logic [3:0] dr, input logic [3:0] dd, input logic rdy);
    int sel;
    bit pop, ok;
    int r;
    sel = -1;
    pop = (m_cnt > 0) && rdy;
    ok  = (m_cnt < DEPTH) || pop;
    for (int i = 0; i < WIDTH; i++) if (m_pend[i] && sel < 0) sel = i;
    if (pop) m_cnt--;
    if (sel >= 0 && ok) begin
      exp_q.push_back('{sel, m_pst[sel], m_ptm[sel]});
      m_cnt++;
      m_pend[sel] = 0;
    end
    for (int i = 0; i < WIDTH; i++) begin
`ifdef TS_EVENT_KEEPER_EN
      r = dr[i] ? int'(dd[i]) : m_lvl[i];
`else
      r = dr[i] ? int'(dd[i]) : 2;
`endif
      if (r != m_lvl[i]) begin
        if (m_pend[i]) m_ovf = 1;
        m_pend[i] = 1;
        m_pst[i]  = r;
        m_ptm[i]  = m_t;
        m_lvl[i]  = r;
      end
    end
    m_t = (m_t + 1) % (1 << TS_W);
  endfunction

  // One cycle: compare visible state, apply inputs, advance model, wait for next falling edge
  task automatic cyc(input logic [3:0] dr, input logic [3:0] dd, input logic rdy);
    chk("count",    32'(count),    32'(m_cnt));
    chk("level",    32'(level),    32'(m_level()));
    chk("overflow", 32'(overflow), 32'(m_ovf));
    chk("ev_valid", 32'(ev_valid), 32'(m_cnt > 0));
    drive    = dr;
    d        = dd;
    ev_ready = rdy;
    m_step(dr, dd, rdy);
    @(negedge clk);
  endtask

  // Monitor: every accepted head event must match the oldest expected event
  always @(negedge clk) begin
    #1;
    if (rst_n && ev_valid && ev_ready) begin
      if (exp_q.size() == 0) begin
        n_chk++;
        $display("FAIL ev_unexpected: got line %0d state %0b time %0d, expected none", ev_line, ev_state, ev_time);
      end else begin
        ev_t e;
        e = exp_q.pop_front();
        chk("ev_line",  32'(ev_line),  32'(e.line));
        chk("ev_state", 32'(ev_state), 32'(e.st));
        chk("ev_time",  32'(ev_time),  32'(e.tm));
        last_tm = int'(ev_time);
      end
    end
  end

  logic [3:0] rd, rdd;
  int         last_chg;
  int         guard;

  initial begin
    rst_n = 1'b0; drive = '0; d = '0; ev_ready = 1'b0;
    m_reset();
    repeat (3) @(negedge clk);
    chk("rst_level",    32'(level),    32'h000000AA);
    chk("rst_count",    32'(count),    32'd0);
    chk("rst_valid",    32'(ev_valid), 32'd0);
    chk("rst_overflow", 32'(overflow), 32'd0);
    chk("rst_head",     32'({ev_line, ev_state, ev_time}), 32'd0);
    rst_n = 1'b1;

    // Idle, undriven lines produce nothing
    repeat (10) cyc(4'h0, 4'h0, 1'b1);
    repeat (3)  cyc(4'h0, 4'hF, 1'b1);

    // Drive then release line 1
    cyc(4'b0010, 4'b1110, 1'b1);
    cyc(4'b0000, 4'b0000, 1'b1);
    repeat (5) cyc(4'h0, 4'h0, 1'b1);

    // All four lines change together while the consumer stalls
    repeat (6) cyc(4'hF, 4'h5, 1'b0);
    chk("simul_count", 32'(count), 32'd4);
    repeat (6) cyc(4'hF, 4'h5, 1'b1);

    // Toggle line 0 every cycle with the consumer stalled: fill, then coalesce
    for (int k = 0; k < 20; k++) begin
      last_chg = m_t;
      cyc(4'hF, {3'b010, k[0]}, 1'b0);
    end
    chk("full_count",    32'(count),    32'd8);
    chk("full_overflow", 32'(overflow), 32'd1);
    repeat (12) cyc(4'hF, 4'h5, 1'b1);
    chk("last_evt_time", 32'(last_tm),  32'(last_chg));

    // Fill, drain to five entries, then reset mid-drain
    rdd = 4'h0;
    guard = 0;
    while (m_cnt < DEPTH && guard < 30) begin
      rdd = ~rdd;
      cyc(4'hF, rdd, 1'b0);
      guard++;
    end
    guard = 0;
    while (m_cnt > 5 && guard < 30) begin
      cyc(4'hF, rdd, 1'b1);
      guard++;
    end
    chk("pre_rst_count", 32'(count), 32'd5);
    rst_n = 1'b0; drive = '0; d = '0; ev_ready = 1'b0;
    m_reset();
    @(negedge clk);
    chk("mid_rst_valid",    32'(ev_valid), 32'd0);
    chk("mid_rst_count",    32'(count),    32'd0);
    chk("mid_rst_overflow", 32'(overflow), 32'd0);
    chk("mid_rst_level",    32'(level),    32'h000000AA);
    rst_n = 1'b1;

    // Random traffic with intermittent backpressure
    rd  = '0;
    rdd = '0;
    repeat (400) begin
      if ($urandom_range(0, 9) < 3) rd  = 4'($urandom);
      if ($urandom_range(0, 9) < 3) rdd = 4'($urandom);
      cyc(rd, rdd, ($urandom_range(0, 3) != 0));
    end

    // Final drain with inputs held
    guard = 0;
    while ((m_cnt > 0 || m_any_pend()) && guard < 60) begin
      cyc(rd, rdd, 1'b1);
      guard++;
    end
    chk("drain_bound", 32'(guard < 60), 32'd1);
    repeat (2) cyc(rd, rdd, 1'b1);
    chk("leftover_expected", 32'(exp_q.size()), 32'd0);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
